// File: rtl/ysyx_22051013_clint.sv
// ysyx_22051013_clint: core-local interruptor holding msip, mtimecmp and mtime,
// answering one data-side access at a time through an IDLE/ACK handshake.
module ysyx_22051013_clint #(
   parameter logic [63:0] BASE = 64'h0000_0000_0200_0000,
   parameter int unsigned DIV  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clint_ena,
   input  logic        core_re,
   input  logic        core_we,
   input  logic        core_ready,
   input  logic [63:0] core_addr,
   input  logic [7:0]  core_mask,
   input  logic [63:0] core_data_i,
   output logic        clint_valid,
   output logic [63:0] clint_data_o,
   output logic        timer_irq,
   output logic        soft_irq,
   output logic [63:0] mtime_o
);

   localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
   localparam logic [12:0]   SEL_MSIP = 13'h0000;
   localparam logic [12:0]   SEL_CMP  = 13'h0800;
   localparam logic [12:0]   SEL_TIME = 13'h17FF;

   typedef enum logic {IDLE, ACK} state_e;

   state_e        state_q, state_d;
   logic          valid_q, valid_d;
   logic [63:0]   rdata_q, rdata_d;
   logic          msip_q, msip_d;
   logic [63:0]   cmp_q, cmp_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [PW-1:0] pre_q, pre_d;

   logic [63:0] off;
   logic [12:0] sel;
   logic        hit_msip, hit_cmp, hit_time;
   logic        accept, tick;
   logic [63:0] wmask, mtime_nx, rd_mux;
   logic        unused_off;

   assign off        = core_addr - BASE;
   assign sel        = off[15:3];
   assign unused_off = ^{off[63:16], off[2:0]};

   assign hit_msip = (sel == SEL_MSIP);
   assign hit_cmp  = (sel == SEL_CMP);
   assign hit_time = (sel == SEL_TIME);

   // ACK never samples a new request, so a held access commits only once
   assign accept = (state_q == IDLE) & clint_ena & (core_re | core_we);
   assign tick   = (pre_q == PRE_MAX);

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign wmask[i*8 +: 8] = {8{core_mask[i]}};
   end

   assign mtime_nx = tick ? (mtime_q + 64'd1) : mtime_q;

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         hit_msip: rd_mux = {63'd0, msip_q};
         hit_cmp:  rd_mux = cmp_q;
         hit_time: rd_mux = mtime_q;
         default:  rd_mux = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      msip_d  = msip_q;
      cmp_d   = cmp_q;
      mtime_d = mtime_nx;
      pre_d   = tick ? '0 : pre_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACK;
               valid_d = 1'b1;
               rdata_d = rd_mux;
            end
         end
         ACK: begin
            if (core_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
      endcase

      // Unwritten mtime lanes keep the ticked value, not the stale one
      if (accept && core_we) begin
         unique case (1'b1)
            hit_msip: if (core_mask[0]) msip_d = core_data_i[0];
            hit_cmp:  cmp_d   = (core_data_i & wmask) | (cmp_q & ~wmask);
            hit_time: mtime_d = (core_data_i & wmask) | (mtime_nx & ~wmask);
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         rdata_q <= '0;
         msip_q  <= 1'b0;
         cmp_q   <= '1;
         mtime_q <= '0;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         msip_q  <= msip_d;
         cmp_q   <= cmp_d;
         mtime_q <= mtime_d;
         pre_q   <= pre_d;
      end
   end

   assign clint_valid  = valid_q;
   assign clint_data_o = rdata_q;
   assign timer_irq    = (mtime_q >= cmp_q);
   assign soft_irq     = msip_q;
   assign mtime_o      = mtime_q;

endmodule
